// File: rtl/inst_matching_bridge.sv
// inst_matching_bridge: matches in-order memory fetch responses to the
// addresses of the requests that produced them. Each outstanding request
// carries a kill flag, so responses to flushed fetches are consumed but
// never forwarded.
// Optional feature: define MIST1032ISA_INST_BRIDGE_FAULT_KILL_EN to kill every
// remaining outstanding request once a forwarded response page-faults.
module inst_matching_bridge #(
  parameter int DEPTH   = 4,
  parameter int DEPTH_N = 2
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iREQ_VALID,
  input  logic [31:0]        iREQ_ADDR,
  input  logic               iFLUSH,
  input  logic               iRESP_VALID,
  input  logic               iRESP_PAGEFAULT,
  input  logic [63:0]        iRESP_DATA,
  output logic               oFULL,
  output logic [DEPTH_N:0]   oCOUNT,
  output logic               oRESP_VALID,
  output logic [31:0]        oRESP_ADDR,
  output logic               oRESP_PAGEFAULT,
  output logic [63:0]        oRESP_DATA,
  output logic               oUNDERFLOW
);

  localparam logic [DEPTH_N:0] FULL_CNT = (DEPTH_N+1)'(DEPTH);

  logic [DEPTH-1:0][31:0] addr_q;
  logic [DEPTH-1:0]       kill_q;
  logic [DEPTH_N-1:0]     wr_ptr, rd_ptr;
  logic [DEPTH_N:0]       count;

  logic push, pop, pop_kill, fault_kill, kill_set;

  assign oFULL  = (count == FULL_CNT);
  assign oCOUNT = count;

  // A full FIFO drops the request even when a pop frees a slot this cycle.
  assign push = iREQ_VALID && !oFULL;
  assign pop  = iRESP_VALID && (count != '0);

  // A flush on the popping edge also kills the entry leaving the FIFO.
  assign pop_kill = kill_q[rd_ptr] | iFLUSH;

`ifdef MIST1032ISA_INST_BRIDGE_FAULT_KILL_EN
  assign fault_kill = pop && !pop_kill && iRESP_PAGEFAULT;
`else
  assign fault_kill = 1'b0;
`endif

  // Marking every slot is safe: empty slots get their flag cleared on push.
  assign kill_set = iFLUSH | fault_kill;

  // Per-entry kill flags; the slot written this cycle always starts alive.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      kill_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == DEPTH_N'(i)))
          kill_q[i] <= 1'b0;
        else if (kill_set)
          kill_q[i] <= 1'b1;
      end
    end
  end

  // Address storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge iCLOCK) begin
    if (push) addr_q[wr_ptr] <= iREQ_ADDR;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Response register: updates only for live pops, otherwise holds.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oRESP_VALID     <= 1'b0;
      oRESP_ADDR      <= '0;
      oRESP_PAGEFAULT <= 1'b0;
      oRESP_DATA      <= '0;
      oUNDERFLOW      <= 1'b0;
    end else begin
      oRESP_VALID <= pop && !pop_kill;
      if (pop && !pop_kill) begin
        oRESP_ADDR      <= addr_q[rd_ptr];
        oRESP_PAGEFAULT <= iRESP_PAGEFAULT;
        oRESP_DATA      <= iRESP_DATA;
      end
      if (iRESP_VALID && (count == '0)) oUNDERFLOW <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_matching_bridge.sv
// Scoreboard bench for inst_matching_bridge: a queue-based reference model
// predicts each forwarded response and the occupancy flags; a negedge monitor
// compares DUT responses against the expected-response queue.
module tb_inst_matching_bridge;
  localparam int DEPTH = 4;
  localparam int DEPTH_N = 2;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iREQ_VALID, iFLUSH, iRESP_VALID, iRESP_PAGEFAULT;
  logic [31:0] iREQ_ADDR;
  logic [63:0] iRESP_DATA;
  logic        oFULL, oRESP_VALID, oRESP_PAGEFAULT, oUNDERFLOW;
  logic [DEPTH_N:0] oCOUNT;
  logic [31:0] oRESP_ADDR;
  logic [63:0] oRESP_DATA;

  inst_matching_bridge #(.DEPTH(DEPTH), .DEPTH_N(DEPTH_N)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iREQ_VALID(iREQ_VALID), .iREQ_ADDR(iREQ_ADDR), .iFLUSH(iFLUSH),
    .iRESP_VALID(iRESP_VALID), .iRESP_PAGEFAULT(iRESP_PAGEFAULT), .iRESP_DATA(iRESP_DATA),
    .oFULL(oFULL), .oCOUNT(oCOUNT), .oRESP_VALID(oRESP_VALID), .oRESP_ADDR(oRESP_ADDR),
    .oRESP_PAGEFAULT(oRESP_PAGEFAULT), .oRESP_DATA(oRESP_DATA), .oUNDERFLOW(oUNDERFLOW)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct { logic [31:0] addr; bit kill; } ent_t;
  typedef struct { int cyc; logic [31:0] addr; bit pf; logic [63:0] data; } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  bit   m_uf;
  int   cycn = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge iCLOCK) cycn <= cycn + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every presented response must be the one predicted for this cycle.
  always @(negedge iCLOCK) begin
    if (inRESET === 1'b1) begin
      if (oRESP_VALID) begin
        if (sb.size() == 0 || sb[0].cyc != cycn) begin
          checks++; failures++;
          $display("FAIL resp_unexpected actual_addr=%0h cyc=%0d", oRESP_ADDR, cycn);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_addr", 64'(oRESP_ADDR), 64'(e.addr));
          chk("resp_pf", 64'(oRESP_PAGEFAULT), 64'(e.pf));
          chk("resp_data", oRESP_DATA, e.data);
        end
      end else if (sb.size() != 0 && sb[0].cyc == cycn) begin
        exp_t e;
        e = sb.pop_front();
        checks++; failures++;
        $display("FAIL resp_missing actual=none expected_addr=%0h", e.addr);
      end
    end
  end

  task automatic chk_state();
    chk("count", 64'(oCOUNT), 64'(mq.size()));
    chk("full", 64'(oFULL), 64'(mq.size() == DEPTH));
    chk("underflow", 64'(oUNDERFLOW), 64'(m_uf));
  endtask

  // One clock cycle: check settled state, then apply inputs and advance the model.
  task automatic cyc(input bit rv, input logic [31:0] a, input bit fl,
                     input bit sv, input bit pf, input logic [63:0] d);
    bit full, push, pop;
    ent_t e;
    @(posedge iCLOCK); #1;
    chk_state();
    iREQ_VALID = rv; iREQ_ADDR = a; iFLUSH = fl;
    iRESP_VALID = sv; iRESP_PAGEFAULT = pf; iRESP_DATA = d;
    full = (mq.size() == DEPTH);
    push = rv && !full;
    pop  = sv && (mq.size() != 0);
    if (sv && mq.size() == 0) m_uf = 1'b1;
    if (fl) foreach (mq[i]) mq[i].kill = 1'b1;
    if (pop) begin
      e = mq.pop_front();
      if (!e.kill) begin
        sb.push_back('{cycn + 1, e.addr, pf, d});
`ifdef MIST1032ISA_INST_BRIDGE_FAULT_KILL_EN
        if (pf) foreach (mq[i]) mq[i].kill = 1'b1;
`endif
      end
    end
    if (push) mq.push_back('{a, 1'b0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 32'h0, 0, 0, 0, 64'h0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, 64'(oRESP_VALID), 64'h0);
    chk({nm, "_count"}, 64'(oCOUNT), 64'h0);
    chk({nm, "_full"}, 64'(oFULL), 64'h0);
    chk({nm, "_uf"}, 64'(oUNDERFLOW), 64'h0);
    chk({nm, "_addr"}, 64'(oRESP_ADDR), 64'h0);
    chk({nm, "_data"}, oRESP_DATA, 64'h0);
    chk({nm, "_pf"}, 64'(oRESP_PAGEFAULT), 64'h0);
  endtask

  initial begin
    inRESET = 1'b0;
    iREQ_VALID = 0; iREQ_ADDR = 0; iFLUSH = 0;
    iRESP_VALID = 0; iRESP_PAGEFAULT = 0; iRESP_DATA = 0;
    m_uf = 1'b0;
    #2;
    chk_zero("reset");
    @(negedge iCLOCK); inRESET = 1'b1;

    // Response with nothing outstanding.
    cyc(0, 0, 0, 1, 0, 64'hdead);
    idle(1);
    chk("uf_sticky", 64'(oUNDERFLOW), 64'h1);
    chk("uf_count", 64'(oCOUNT), 64'h0);

    // Fill, overflow attempt, drain in order.
    for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 32'(i * 8), 0, 0, 0, 0);
    cyc(1, 32'h120, 0, 0, 0, 0);
    chk("full_flag", 64'(oFULL), 64'h1);
    chk("full_count", 64'(oCOUNT), 64'h4);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 64'h1000 + 64'(i));
    idle(2);

    // Flush with a simultaneous push: only the new request survives.
    for (int i = 0; i < 3; i++) cyc(1, 32'h180 + 32'(i * 8), 0, 0, 0, 0);
    cyc(1, 32'h200, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 64'h2000 + 64'(i));
    idle(2);

    // Full FIFO with push and pop together: push dropped.
    for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 32'(i * 8), 0, 0, 0, 0);
    cyc(1, 32'h3f0, 0, 1, 0, 64'h3000);
    idle(1);
    chk("pushpop_count", 64'(oCOUNT), 64'h3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 64'h3100 + 64'(i));
    idle(2);

    // Page-faulting first response of two.
    cyc(1, 32'h400, 0, 0, 0, 0);
    cyc(1, 32'h408, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 64'h4000);
    cyc(0, 0, 0, 1, 0, 64'h4001);
    idle(2);

    // Asynchronous reset with requests in flight.
    for (int i = 0; i < 3; i++) cyc(1, 32'h500 + 32'(i * 8), 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    #2;
    inRESET = 1'b0;
    #1;
    chk_zero("midreset");
    mq.delete(); sb.delete(); m_uf = 1'b0;
    iREQ_VALID = 0; iFLUSH = 0; iRESP_VALID = 0; iRESP_PAGEFAULT = 0;
    @(negedge iCLOCK); inRESET = 1'b1;
    cyc(1, 32'h40, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 64'h4040);
    idle(1);
    chk("post_reset_addr", 64'(oRESP_ADDR), 64'h40);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc,
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0),
          {$urandom, $urandom});
    end
    idle(DEPTH + 2);
    while (mq.size() != 0) cyc(0, 0, 0, 1, 0, 64'h5a5a);
    idle(3);
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/inst_matching_bridge.md
INST_MATCHING_BRIDGE -- requirements
Module: inst_matching_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4, max outstanding fetch requests (power of 2, 2..16).
REQ-002 SHALL have parameter DEPTH_N, default 2, log2(DEPTH).
REQ-003 SHALL have port iCLOCK  input  1  sole clock, rising edge.
REQ-004 SHALL have port inRESET  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iREQ_VALID  input  1  fetch request accepted by memory this cycle.
REQ-006 SHALL have port iREQ_ADDR  input  32  address of that request.
REQ-007 SHALL have port iFLUSH  input  1  instruction queue flush; kill all in-flight requests.
REQ-008 SHALL have port iRESP_VALID  input  1  memory returns data for the oldest request.
REQ-009 SHALL have port iRESP_PAGEFAULT  input  1  response faulted.
REQ-010 SHALL have port iRESP_DATA  input  64  response data.
REQ-011 SHALL have port oFULL  output  1  DEPTH requests outstanding; fetch must stall.
REQ-012 SHALL have port oCOUNT  output  DEPTH_N+1  outstanding request count.
REQ-013 SHALL have port oRESP_VALID  output  1  matched, non-killed response.
REQ-014 SHALL have port oRESP_ADDR  output  32  request address matched to the response.
REQ-015 SHALL have port oRESP_PAGEFAULT  output  1  registered iRESP_PAGEFAULT.
REQ-016 SHALL have port oRESP_DATA  output  64  registered iRESP_DATA.
REQ-017 SHALL have port oUNDERFLOW  output  1  sticky: response arrived with nothing outstanding.

Function
REQ-018 SHALL hold an in-order FIFO of DEPTH entries {addr, kill}; push on iREQ_VALID && !oFULL, pop on iRESP_VALID && oCOUNT!=0.
REQ-019 SHALL drive oFULL = (count==DEPTH) from registered count; iREQ_VALID while full is dropped even if a pop occurs the same cycle.
REQ-020 SHALL update count by +1 on push only, -1 on pop only, unchanged on both or neither; pointers wrap modulo DEPTH.
REQ-021 SHALL assert oRESP_VALID exactly one cycle after a pop whose entry kill=0, with oRESP_ADDR/DATA/PAGEFAULT registered in that same cycle.
REQ-022 SHALL, on iFLUSH, set kill on every entry occupied before that edge, including one popped that same cycle; an entry pushed the same cycle is not killed.
REQ-023 SHALL pop killed entries normally (count decrements) but keep oRESP_VALID low for them.
REQ-024 SHALL hold oRESP_ADDR/DATA/PAGEFAULT at last values when oRESP_VALID is low.
REQ-025 SHALL ignore iRESP_VALID with count==0 (no pop, no oRESP_VALID) and set oUNDERFLOW until reset.

Reset
REQ-026 SHALL, while inRESET=0, asynchronously clear pointers, count, kill bits, oRESP_VALID, oRESP_ADDR, oRESP_DATA, oRESP_PAGEFAULT and oUNDERFLOW to 0; oFULL=0.
REQ-027 SHALL discard all in-flight state on reset mid-operation; first edge after release behaves as empty FIFO.

Configuration
REQ-028 SHALL, with MIST1032ISA_INST_BRIDGE_FAULT_KILL_EN defined, set kill on all remaining entries when a non-killed pagefault response is popped (entries pushed that cycle unaffected).
REQ-029 SHALL, without the macro, forward faulted responses only; other entries are not killed.

Verification
REQ-030 SHALL verify: push 0x100,0x108,0x110,0x118 -> oFULL=1, oCOUNT=4; 5th push 0x120 dropped; 4 responses -> oRESP_ADDR 0x100..0x118 in order.
REQ-031 SHALL verify: 3 outstanding, iFLUSH with push 0x200 same cycle -> next 3 responses suppressed, 4th gives oRESP_ADDR=0x200.
REQ-032 SHALL verify: response with count 0 -> oRESP_VALID=0, oUNDERFLOW=1, oCOUNT stays 0.
REQ-033 SHALL verify: full FIFO, push+pop same cycle -> push dropped, oCOUNT=3.
REQ-034 SHALL verify: 2 outstanding, first response pagefault -> oRESP_PAGEFAULT=1; second response forwarded without macro, suppressed with it.
REQ-035 SHALL verify: inRESET low mid-burst with 3 outstanding -> all outputs 0 immediately; after release, push 0x40 and response -> oRESP_ADDR=0x40.
